data_bus_ram: RTL and testbench

//  1-master/4-slave 16-bit data bus decoder with an integrated synchronous
//  16-bit block RAM as slave 0. Sits between the CPU data port and the

---
 rtl/data_bus_ram.sv | 78 +++++++
 tb/tb_data_bus_ram.sv | 133 +++++++++++++
 2 files changed

// File: rtl/data_bus_ram.sv
// Single-master, four-slave 16-bit data bus decoder. Slave 0 is an internal
// synchronous block RAM; slaves 1..3 are external with 1-cycle read latency.
module data_bus_ram #(
  parameter int    adr_width = 14,
  parameter string init_file = ""
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] m_a,
  input  logic        m_we,
  input  logic [15:0] m_do,
  output logic [15:0] m_di,
  output logic [15:0] s1_a,
  output logic        s1_we,
  output logic [15:0] s1_do,
  input  logic [15:0] s1_di,
  output logic [15:0] s2_a,
  output logic        s2_we,
  output logic [15:0] s2_do,
  input  logic [15:0] s2_di,
  output logic [15:0] s3_a,
  output logic        s3_we,
  output logic [15:0] s3_do,
  input  logic [15:0] s3_di
);

  localparam int depth = 2 ** (adr_width - 1);

  logic [1:0]           sel;
  logic [1:0]           sel_q;
  logic [adr_width-2:0] idx;
  logic [15:0]          ram_q;
  logic [15:0]          mem [depth];

  // Byte address bit 0 is dropped; upper bits inside region 0 alias.
  assign sel = m_a[15:14];
  assign idx = m_a[adr_width-1:1];

  assign s1_a  = m_a;
  assign s2_a  = m_a;
  assign s3_a  = m_a;
  assign s1_do = m_do;
  assign s2_do = m_do;
  assign s3_do = m_do;
  assign s1_we = m_we && (sel == 2'd1);
  assign s2_we = m_we && (sel == 2'd2);
  assign s3_we = m_we && (sel == 2'd3);

  // Write is kept in its own process so the array maps onto block RAM;
  // reset only gates the write, contents survive it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst && m_we && (sel == 2'd0)) begin
      mem[idx] <= m_do;
    end
  end

  // Read-first: ram_q captures the word before any same-cycle write lands.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      sel_q <= 2'd0;
      ram_q <= 16'h0000;
    end else begin
      sel_q <= sel;
      ram_q <= mem[idx];
    end
  end

  always_comb begin
    m_di = ram_q;
    case (sel_q)
      2'd1:    m_di = s1_di;
      2'd2:    m_di = s2_di;
      2'd3:    m_di = s3_di;
      default: m_di = ram_q;
    endcase
  end

endmodule

// File: tb/tb_data_bus_ram.sv
// Bench for data_bus_ram: directed bus cycles, combinational decode checks,
// and a queued scoreboard for the one-cycle-late m_di read data.
module tb_data_bus_ram;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [15:0] m_a     = 16'h0000;
    logic        m_we    = 1'b0;
    logic [15:0] m_do    = 16'h0000;
    logic [15:0] m_di;
    logic [15:0] s1_a, s2_a, s3_a;
    logic        s1_we, s2_we, s3_we;
    logic [15:0] s1_do, s2_do, s3_do;
    logic [15:0] s1_di = 16'hAAAA;
    logic [15:0] s2_di = 16'h00FF;
    logic [15:0] s3_di = 16'h1357;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic        rd_tag  = 1'b0;
    logic        valid_q = 1'b0;

    data_bus_ram #(.adr_width(14), .init_file("")) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_a(m_a), .m_we(m_we), .m_do(m_do), .m_di(m_di),
        .s1_a(s1_a), .s1_we(s1_we), .s1_do(s1_do), .s1_di(s1_di),
        .s2_a(s2_a), .s2_we(s2_we), .s2_do(s2_do), .s2_di(s2_di),
        .s3_a(s3_a), .s3_we(s3_we), .s3_do(s3_do), .s3_di(s3_di)
    );

    always #5 sys_clk = ~sys_clk;

    // Tagged cycles expect their data on the bus after the next edge.
    always @(posedge sys_clk) valid_q <= rd_tag;

    always @(negedge sys_clk) begin
        if (valid_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: m_di=%h with no expected value queued", m_di);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (m_di !== e) begin
                    errors++;
                    $display("FAIL rd_data: m_di=%h expected %h", m_di, e);
                end
            end
        end
    end

    // One bus cycle: inputs change on the falling edge, away from sampling.
    task automatic bus(input logic rst, input logic [15:0] a, input logic we,
                       input logic [15:0] d, input logic tag, input logic [15:0] e);
        @(negedge sys_clk);
        sys_rst = rst;
        m_a     = a;
        m_we    = we;
        m_do    = d;
        rd_tag  = tag;
        if (tag) exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_decode(input logic [2:0] we_exp, input logic [15:0] a, input logic [15:0] d);
        #1;
        check("slave_we", {29'd0, s3_we, s2_we, s1_we}, {29'd0, we_exp});
        check("slave_a", {s1_a, s3_a}, {a, a});
        check("slave_do", {s2_do, s3_do}, {d, d});
    endtask

    initial begin
        // Reset held for three clocks; m_di reads zero throughout.
        bus(1'b0, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0000);
        bus(1'b0, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0000);
        bus(1'b0, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0000);

        // RAM writes, then reads including the ignored bit 0.
        bus(1'b1, 16'h0010, 1'b1, 16'hBEEF, 1'b0, 16'h0000);
        check_decode(3'b000, 16'h0010, 16'hBEEF);
        bus(1'b1, 16'h0012, 1'b1, 16'h1234, 1'b0, 16'h0000);
        bus(1'b1, 16'h0020, 1'b1, 16'h7777, 1'b0, 16'h0000);
        bus(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
        bus(1'b1, 16'h0012, 1'b0, 16'h0000, 1'b1, 16'h1234);
        bus(1'b1, 16'h0011, 1'b0, 16'h0000, 1'b1, 16'hBEEF);

        // Writes to external regions reach exactly one slave.
        bus(1'b1, 16'h4020, 1'b1, 16'h5555, 1'b1, 16'hAAAA);
        check_decode(3'b001, 16'h4020, 16'h5555);
        bus(1'b1, 16'h8000, 1'b1, 16'h6666, 1'b1, 16'h00FF);
        check_decode(3'b010, 16'h8000, 16'h6666);
        bus(1'b1, 16'hC000, 1'b1, 16'h9999, 1'b1, 16'h1357);
        check_decode(3'b100, 16'hC000, 16'h9999);
        bus(1'b1, 16'h0020, 1'b0, 16'h0000, 1'b1, 16'h7777);
        check_decode(3'b000, 16'h0020, 16'h0000);

        // Back-to-back reads across regions.
        bus(1'b1, 16'h4000, 1'b0, 16'h0000, 1'b1, 16'hAAAA);
        bus(1'b1, 16'h8000, 1'b0, 16'h0000, 1'b1, 16'h00FF);
        bus(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'hBEEF);

        // Read-during-write returns the old word, then the new one.
        bus(1'b1, 16'h0010, 1'b1, 16'h0F0F, 1'b1, 16'hBEEF);
        bus(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0F0F);

        // Writes in reset are blocked for RAM, decode still drives slaves.
        bus(1'b0, 16'h0010, 1'b1, 16'hDEAD, 1'b1, 16'h0000);
        bus(1'b0, 16'h4004, 1'b1, 16'h2222, 1'b1, 16'h0000);
        check_decode(3'b001, 16'h4004, 16'h2222);
        bus(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0F0F);
        bus(1'b1, 16'h0012, 1'b0, 16'h0000, 1'b1, 16'h1234);

        bus(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        bus(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge sys_clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
